hazard_ctrl: RTL
================

# hazard_ctrl

Parametrised hazard and forwarding controller for the five-stage MIPS pipeline. It consumes the per-instruction write and use information produced by decode, which is Addr, GRFWE, Tnew, TuseRs, TuseRt and MDInstr, for the instruction in D. It tracks in-flight writers in a stage scoreboard and a mult/div busy counter. Each cycle it issues the D-stage stall and the D-stage operand forwarding selects.

## Interface
- ADDR_W, 5, register address width
- NSTAGE, 3, tracked stages after D (entry 0 = E, 1 = M, 2 = W)
- TIME_W, 2, width of Tnew/Tuse; all-ones Tuse means "operand unused"
- MULT_CYC, 5, mult/multu busy cycles
- DIV_CYC, 10, div/divu busy cycles
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  invalidate all scoreboard entries
- d_valid  in  1  D holds a real instruction
- d_addr  in  ADDR_W  destination register
- d_grfwe  in  1  D instruction writes GRF
- d_tnew  in  TIME_W  cycles from D until result is forwardable
- d_rs, d_rt  in  ADDR_W  source registers
- d_tuse_rs, d_tuse_rt  in  TIME_W  cycles from D until operand is needed
- d_md_instr  in  1  D is mult/div/mfhi/mflo/mthi/mtlo
- d_md_start  in  1  D is mult/multu/div/divu
- d_md_is_div  in  1  qualifies d_md_start
- stall  out  1  hold PC and D, insert bubble into E
- fwd_rs_sel, fwd_rt_sel  out  $clog2(NSTAGE+1)  0 = GRF, k+1 = entry k
- md_busy  out  1  mult/div counter non-zero

## Operation
- Scoreboard: NSTAGE entries {valid, addr, we, rem}. An entry is live when valid & we & addr != 0.
- Issue: D issues when d_valid & !stall. On issue, entry0 <= {1, d_addr, d_grfwe, sat(d_tnew-1)}, where sat floors at 0. On stall or !d_valid, entry0 <= bubble (valid=0).
- Shift: entry[k+1] <= entry[k] with rem <= sat(rem-1) every cycle, regardless of stall. The last entry drops off.
- Match for rs: the youngest live entry (lowest k) with addr == d_rs. Only that entry counts; older entries are ignored. d_rs == 0 never matches. The same rules apply to rt.
- Stall when any of the following holds:
  - the rs match exists, d_tuse_rs != all-ones, and rem > d_tuse_rs;
  - the same condition holds for rt;
  - d_md_instr & md_busy.
- Stall is gated by d_valid.
- Forward select: fwd_x_sel = k+1 if the youngest match k has rem == 0; otherwise 0.
- MD counter: on issue with d_md_start, cnt <= DIV_CYC or MULT_CYC. Otherwise it decrements to 0 and holds. md_busy = (cnt != 0).
- Flush: all entries valid <= 0 on the next edge. Flush overrides issue and shift. The MD counter is unaffected.
- Reset: all entries invalid with rem=0, cnt=0. Reset may arrive mid-operation; in-flight state is discarded.

## Timing
- stall, fwd_*_sel and md_busy are combinational from the D inputs and registered state. There is zero-cycle latency from the D inputs.
- Outputs during reset with d_valid=0: stall=0, fwd_rs_sel=fwd_rt_sel=0, md_busy=0.
- A scoreboard update is visible one cycle after the edge.
- Simultaneous flush and stall: flush wins. The next cycle has an empty scoreboard, and stall can only come from md_busy.
- Simultaneous md start issue and md_busy: cannot occur, because stall blocks the issue. A reload can only happen after cnt reaches 0.
- rem never wraps: saturating decrement only.

## Structure
- Package hazard_pkg holds:
  - the scoreboard entry typedef;
  - the TUSE_NONE constant (all-ones);
  - the FWD_GRF = 0 encoding;
  - the sat_dec helper function.
- Sub-module md_busy_counter contains the MD counter: load value, decrement, busy flag.
- The scoreboard shift, youngest-match priority encoder and stall compare stay in hazard_ctrl.

## Test plan
- Reset: pulse rst_n low mid-stream with lw $8 in E → stall=0, md_busy=0, fwd_*=0. After release, add $9,$8,$8 sees no match.
- Load-use: lw $8 (tnew 3), then add using $8 (tuse_rs 1) → exactly 1 stall cycle. Next cycle the match is in M with rem 1, so no stall and fwd_rs_sel=0. One cycle later the producer is in W, rem 0.
- Branch after ALU: ori $9 (tnew 2), then beq $9,$9 (tuse 0) → 1 stall cycle. Then fwd_rs_sel=fwd_rt_sel=2 (M).
- $0 and priority:
  - Writer to $0 followed by a consumer of $0 → never stalls, fwd=0.
  - addi $5 in M (rem 0) with lw $5 in E (rem 2), consumer tuse 1 → stall, because the youngest match wins.
- MD busy: mult (MULT_CYC=5), then mfhi → md_busy high for 5 cycles, and mfhi stalls 5 cycles. A div reload gives 10 busy cycles.
- Flush: flush asserted while stall=1 from lw $8 in E → the next cycle has stall=0 and fwd=0 for $8.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types, encodings and helpers for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned HZ_ADDR_W = 5;
  localparam int unsigned HZ_TIME_W = 2;

  // Tuse value meaning the operand is not read at all.
  localparam logic [HZ_TIME_W-1:0] TUSE_NONE = '1;

  // Forward select encoding for "take the operand from the register file".
  localparam int unsigned FWD_GRF = 0;

  // One in-flight writer tracked after D.
  typedef struct packed {
    logic                 valid;
    logic [HZ_ADDR_W-1:0] addr;
    logic                 we;
    logic [HZ_TIME_W-1:0] rem;
  } sb_entry_t;

  // Decrement that floors at zero so remaining time never wraps.
  function automatic logic [HZ_TIME_W-1:0] sat_dec(input logic [HZ_TIME_W-1:0] v);
    return (v == '0) ? '0 : v - HZ_TIME_W'(1);
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Mult/div unit busy tracker: loads a latency on start, counts down to zero.
module md_busy_counter
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic is_div,
  output logic busy
);

  localparam int unsigned CNT_MAX = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Next count: reload on start, otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// D-stage stall and operand-forwarding controller for the five-stage pipeline.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned ADDR_W   = HZ_ADDR_W,
  parameter int unsigned NSTAGE   = 3,
  parameter int unsigned TIME_W   = HZ_TIME_W,
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             d_valid,
  input  logic [ADDR_W-1:0]                d_addr,
  input  logic                             d_grfwe,
  input  logic [TIME_W-1:0]                d_tnew,
  input  logic [ADDR_W-1:0]                d_rs,
  input  logic [ADDR_W-1:0]                d_rt,
  input  logic [TIME_W-1:0]                d_tuse_rs,
  input  logic [TIME_W-1:0]                d_tuse_rt,
  input  logic                             d_md_instr,
  input  logic                             d_md_start,
  input  logic                             d_md_is_div,
  output logic                             stall,
  output logic [$clog2(NSTAGE+1)-1:0]      fwd_rs_sel,
  output logic [$clog2(NSTAGE+1)-1:0]      fwd_rt_sel,
  output logic                             md_busy
);

  localparam int unsigned FWD_W = $clog2(NSTAGE + 1);

  // Entry 0 is E, higher indices are older stages.
  sb_entry_t sb_q [NSTAGE];
  sb_entry_t sb_d [NSTAGE];

  logic [NSTAGE-1:0]  live;
  logic               rs_hit, rt_hit;
  logic [TIME_W-1:0]  rs_rem, rt_rem;
  int                 rs_idx, rt_idx;
  logic               stall_rs, stall_rt;
  logic               issue;

  // An entry can only be a forwarding source if it really writes a non-zero register.
  always_comb begin
    for (int k = 0; k < NSTAGE; k++) begin
      live[k] = sb_q[k].valid & sb_q[k].we & (sb_q[k].addr != '0);
    end
  end

  // Youngest-match priority encoders: scan oldest to youngest so the lowest index wins.
  always_comb begin
    rs_hit = 1'b0;
    rs_rem = '0;
    rs_idx = 0;
    rt_hit = 1'b0;
    rt_rem = '0;
    rt_idx = 0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (live[k] && (sb_q[k].addr == d_rs)) begin
        rs_hit = 1'b1;
        rs_rem = sb_q[k].rem;
        rs_idx = k;
      end
      if (live[k] && (sb_q[k].addr == d_rt)) begin
        rt_hit = 1'b1;
        rt_rem = sb_q[k].rem;
        rt_idx = k;
      end
    end
  end

  // Stall when a matched producer is still too far from ready, or the MD unit is busy.
  always_comb begin
    stall_rs   = rs_hit && (d_tuse_rs != TUSE_NONE) && (rs_rem > d_tuse_rs);
    stall_rt   = rt_hit && (d_tuse_rt != TUSE_NONE) && (rt_rem > d_tuse_rt);
    stall      = d_valid & (stall_rs | stall_rt | (d_md_instr & md_busy));
    issue      = d_valid & ~stall;
    fwd_rs_sel = (rs_hit && (rs_rem == '0)) ? FWD_W'(rs_idx + 1) : FWD_W'(FWD_GRF);
    fwd_rt_sel = (rt_hit && (rt_rem == '0)) ? FWD_W'(rt_idx + 1) : FWD_W'(FWD_GRF);
  end

  // Scoreboard next state: issue or bubble into E, age everything else; flush clears all.
  always_comb begin
    for (int k = 0; k < NSTAGE; k++) begin
      sb_d[k] = '0;
    end
    if (!flush) begin
      if (issue) begin
        sb_d[0].valid = 1'b1;
        sb_d[0].addr  = d_addr;
        sb_d[0].we    = d_grfwe;
        sb_d[0].rem   = sat_dec(d_tnew);
      end
      for (int k = 1; k < NSTAGE; k++) begin
        sb_d[k]     = sb_q[k-1];
        sb_d[k].rem = sat_dec(sb_q[k-1].rem);
      end
    end
  end

  // Scoreboard registers; shift happens regardless of stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTAGE; k++) begin
        sb_q[k] <= '0;
      end
    end else begin
      sb_q <= sb_d;
    end
  end

  // Mult/div busy tracking; a reload can only happen once the unit is idle.
  md_busy_counter #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_busy (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (issue & d_md_start),
    .is_div (d_md_is_div),
    .busy   (md_busy)
  );

endmodule
